// File: rtl/lockstep_commit_checker.sv
// Pairs in-order commit records from a reference and a variant harness and
// sequences the run through IDLE/RUN/DRAIN to PASS, MISMATCH or SKEW_TIMEOUT.
module lockstep_commit_checker #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8,
  parameter int SKEW_LIMIT = 1024,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              clear,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  output logic [2:0]        state,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  match_count,
  output logic [DATA_W-1:0] mis_a,
  output logic [DATA_W-1:0] mis_b
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;
  localparam int SKEW_W = $clog2(SKEW_LIMIT + 1);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RUN          = 3'd1,
    ST_DRAIN        = 3'd2,
    ST_PASS         = 3'd3,
    ST_MISMATCH     = 3'd4,
    ST_SKEW_TIMEOUT = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    a_wr_q, a_wr_d, a_rd_q, a_rd_d;
  logic [PTR_W-1:0]    b_wr_q, b_wr_d, b_rd_q, b_rd_d;
  logic [DATA_W-1:0]   a_mem_q [DEPTH];
  logic [DATA_W-1:0]   b_mem_q [DEPTH];
  logic [CNT_W-1:0]    match_q, match_d;
  logic [SKEW_W-1:0]   skew_q, skew_d;
  logic [DATA_W-1:0]   mis_a_q, mis_a_d, mis_b_q, mis_b_d;

  logic              active, a_empty, b_empty, a_full, b_full;
  logic              a_push, b_push, pair, heads_eq, mismatch, lone, skew_hit;
  logic [DATA_W-1:0] a_head, b_head;

  assign active  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign a_empty = (a_wr_q == a_rd_q);
  assign b_empty = (b_wr_q == b_rd_q);
  // Full when the wrap bits differ but the addresses coincide.
  assign a_full  = (a_wr_q[ADDR_W] != a_rd_q[ADDR_W]) &&
                   (a_wr_q[ADDR_W-1:0] == a_rd_q[ADDR_W-1:0]);
  assign b_full  = (b_wr_q[ADDR_W] != b_rd_q[ADDR_W]) &&
                   (b_wr_q[ADDR_W-1:0] == b_rd_q[ADDR_W-1:0]);

  assign a_ready  = active && !a_full;
  assign b_ready  = active && !b_full;
  assign a_push   = a_valid && a_ready;
  assign b_push   = b_valid && b_ready;
  assign a_head   = a_mem_q[a_rd_q[ADDR_W-1:0]];
  assign b_head   = b_mem_q[b_rd_q[ADDR_W-1:0]];
  assign pair     = active && !a_empty && !b_empty;
  assign heads_eq = (a_head == b_head);
  assign mismatch = pair && !heads_eq;
  assign lone     = active && (a_empty != b_empty);
  // Timeout fires on the edge where the skew count would reach the limit.
  assign skew_hit = lone && (skew_q == SKEW_W'(SKEW_LIMIT - 1));

  always_comb begin
    state_d = state_q;
    a_wr_d  = a_wr_q + PTR_W'(a_push);
    b_wr_d  = b_wr_q + PTR_W'(b_push);
    a_rd_d  = a_rd_q + PTR_W'(pair);
    b_rd_d  = b_rd_q + PTR_W'(pair);
    match_d = match_q + CNT_W'(pair && heads_eq);
    skew_d  = lone ? skew_q + 1'b1 : '0;
    mis_a_d = mismatch ? a_head : mis_a_q;
    mis_b_d = mismatch ? b_head : mis_b_q;

    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (mismatch)      state_d = ST_MISMATCH;
        else if (skew_hit) state_d = ST_SKEW_TIMEOUT;
        else if (finish)   state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mismatch)      state_d = ST_MISMATCH;
        else if (skew_hit) state_d = ST_SKEW_TIMEOUT;
        else if (a_empty && b_empty && !a_push && !b_push) state_d = ST_PASS;
      end
      default: state_d = state_q;
    endcase

    // Clear flushes everything except the captured mismatch diagnostics.
    if (clear) begin
      state_d = ST_IDLE;
      a_wr_d  = '0;
      a_rd_d  = '0;
      b_wr_d  = '0;
      b_rd_d  = '0;
      match_d = '0;
      skew_d  = '0;
      mis_a_d = mis_a_q;
      mis_b_d = mis_b_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_wr_q  <= '0;
      a_rd_q  <= '0;
      b_wr_q  <= '0;
      b_rd_q  <= '0;
      match_q <= '0;
      skew_q  <= '0;
      mis_a_q <= '0;
      mis_b_q <= '0;
    end else begin
      state_q <= state_d;
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      match_q <= match_d;
      skew_q  <= skew_d;
      mis_a_q <= mis_a_d;
      mis_b_q <= mis_b_d;
    end
  end

  // Record storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clock) begin
    if (a_push) a_mem_q[a_wr_q[ADDR_W-1:0]] <= a_data;
    if (b_push) b_mem_q[b_wr_q[ADDR_W-1:0]] <= b_data;
  end

  assign state       = state_q;
  assign done        = (state_q == ST_PASS) || (state_q == ST_MISMATCH) ||
                       (state_q == ST_SKEW_TIMEOUT);
  assign fail        = (state_q == ST_MISMATCH) || (state_q == ST_SKEW_TIMEOUT);
  assign match_count = match_q;
  assign mis_a       = mis_a_q;
  assign mis_b       = mis_b_q;

endmodule

// File: tb/tb_lockstep_commit_checker.sv
// Directed and randomized bench for lockstep_commit_checker, checked against a
// queue-based behavioural model of the pairing and run-sequencing rules.
module tb_lockstep_commit_checker;

  localparam int DATA_W     = 64;
  localparam int DEPTH      = 8;
  localparam int SKEW_LIMIT = 16;
  localparam int CNT_W      = 32;

  logic              clock, reset, start, finish, clear;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [DATA_W-1:0] a_data, b_data, mis_a, mis_b;
  logic [2:0]        state;
  logic              done, fail;
  logic [CNT_W-1:0]  match_count;

  lockstep_commit_checker #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SKEW_LIMIT(SKEW_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .finish(finish), .clear(clear),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .state(state), .done(done), .fail(fail), .match_count(match_count),
    .mis_a(mis_a), .mis_b(mis_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Behavioural model: the two FIFOs are plain queues.
  logic [63:0] qa[$], qb[$];
  int          m_state = 0;
  logic [31:0] m_match = 0;
  int          m_skew  = 0;
  logic [63:0] m_mis_a = 0, m_mis_b = 0;
  bit          lastA, lastB;
  logic [63:0] srcA[$], srcB[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    checkOutput("state", 64'(state), 64'(m_state));
    checkOutput("done", 64'(done), 64'(m_state >= 3));
    checkOutput("fail", 64'(fail), 64'(m_state >= 4));
    checkOutput("match_count", 64'(match_count), 64'(m_match));
    checkOutput("mis_a", mis_a, m_mis_a);
    checkOutput("mis_b", mis_b, m_mis_b);
  endtask

  // One clock cycle: drive inputs, check readies, advance model, check after the edge.
  task automatic applyStimulus(input logic av, input logic [63:0] ad, input logic bv,
                               input logic [63:0] bd, input logic st, input logic fi,
                               input logic cl);
    bit act, ra, rb, pa, pb, pair, lone, mism;
    int ns, skew_new;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    start = st; finish = fi; clear = cl;
    #1;
    act = (m_state == 1) || (m_state == 2);
    ra  = act && (qa.size() < DEPTH);
    rb  = act && (qb.size() < DEPTH);
    checkOutput("a_ready", 64'(a_ready), 64'(ra));
    checkOutput("b_ready", 64'(b_ready), 64'(rb));
    pa   = av && ra;
    pb   = bv && rb;
    pair = act && (qa.size() > 0) && (qb.size() > 0);
    lone = act && !pair && ((qa.size() > 0) || (qb.size() > 0));
    mism = 1'b0;
    if (pair) mism = (qa[0] != qb[0]);
    ns = m_state;
    if (cl) begin
      ns = 0;
      qa.delete();
      qb.delete();
      m_match = 0;
      m_skew  = 0;
    end else begin
      skew_new = lone ? m_skew + 1 : 0;
      if (m_state == 0 && st) ns = 1;
      else if (act) begin
        if (mism) ns = 4;
        else if (skew_new >= SKEW_LIMIT) ns = 5;
        else if (m_state == 1 && fi) ns = 2;
        else if (m_state == 2 && qa.size() == 0 && qb.size() == 0 && !pa && !pb) ns = 3;
      end
      if (mism) begin
        m_mis_a = qa[0];
        m_mis_b = qb[0];
      end
      if (pair) begin
        if (!mism) m_match = m_match + 1;
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (pa) qa.push_back(ad);
      if (pb) qb.push_back(bd);
      m_skew = skew_new;
    end
    m_state = ns;
    lastA = pa;
    lastB = pb;
    @(posedge clock);
    #1;
    checkModel();
  endtask

  task automatic feed(input int pct_a, input int pct_b, input int max_cycles);
    int n = 0;
    logic av, bv;
    logic [63:0] ad, bd;
    while ((srcA.size() > 0 || srcB.size() > 0) && n < max_cycles &&
           (m_state == 1 || m_state == 2)) begin
      av = (srcA.size() > 0) && ($urandom_range(99) < pct_a);
      bv = (srcB.size() > 0) && ($urandom_range(99) < pct_b);
      ad = '0;
      bd = '0;
      if (av) ad = srcA[0];
      if (bv) bd = srcB[0];
      applyStimulus(av, ad, bv, bd, 1'b0, 1'b0, 1'b0);
      if (lastA) void'(srcA.pop_front());
      if (lastB) void'(srcB.pop_front());
      n++;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitDone(input int max_cycles);
    int n = 0;
    while (m_state < 3 && n < max_cycles) begin
      idleCycle();
      n++;
    end
    checkOutput("done_within_bound", 64'(done), 64'd1);
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    m_state = 0; m_match = 0; m_skew = 0; m_mis_a = 0; m_mis_b = 0;
    checkModel();
    checkOutput("reset_a_ready", 64'(a_ready), 64'd0);
    checkOutput("reset_b_ready", 64'(b_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  task automatic restart();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [63:0] r;
    a_valid = 0; b_valid = 0; a_data = 0; b_data = 0;
    start = 0; finish = 0; clear = 0; reset = 0;
    doReset();

    // Twenty identical records in lockstep, then finish.
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      srcA.push_back(64'h1000 + 64'(i));
      srcB.push_back(64'h1000 + 64'(i));
    end
    feed(100, 100, 100);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    waitDone(20);
    checkOutput("t1_match", 64'(match_count), 64'd20);
    checkOutput("t1_state", 64'(state), 64'd3);
    checkOutput("t1_fail", 64'(fail), 64'd0);

    // A fills its FIFO alone, then B catches up.
    restart();
    for (int i = 0; i < 8; i++) srcA.push_back(64'h2000 + 64'(i));
    feed(100, 0, 50);
    checkOutput("t2_a_full_ready", 64'(a_ready), 64'd0);
    for (int i = 0; i < 8; i++) srcB.push_back(64'h2000 + 64'(i));
    feed(0, 100, 50);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    waitDone(30);
    checkOutput("t2_match", 64'(match_count), 64'd8);
    checkOutput("t2_state", 64'(state), 64'd3);

    // Fifth record differs.
    restart();
    for (int i = 0; i < 4; i++) begin
      srcA.push_back(64'h3000 + 64'(i));
      srcB.push_back(64'h3000 + 64'(i));
    end
    srcA.push_back(64'h1234);
    srcB.push_back(64'h1235);
    feed(100, 100, 50);
    waitDone(20);
    checkOutput("t3_state", 64'(state), 64'd4);
    checkOutput("t3_mis_a", mis_a, 64'h1234);
    checkOutput("t3_mis_b", mis_b, 64'h1235);
    checkOutput("t3_match", 64'(match_count), 64'd4);
    checkOutput("t3_fail", 64'(fail), 64'd1);

    // Clear out of MISMATCH keeps the diagnostics; finish in IDLE does nothing.
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("t3_clear_state", 64'(state), 64'd0);
    checkOutput("t3_clear_mis_a", mis_a, 64'h1234);
    checkOutput("t3_clear_mis_b", mis_b, 64'h1235);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Single lonely record on A times out.
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hABCD, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cnt = 0;
    while (m_state != 5 && cnt < 40) begin
      idleCycle();
      cnt++;
    end
    checkOutput("t4_skew_cycles", 64'(cnt), 64'd16);
    checkOutput("t4_state", 64'(state), 64'd5);
    checkOutput("t4_done_fail", {62'd0, done, fail}, 64'd3);

    // Finish with three records pending on A; B supplies them in DRAIN.
    restart();
    for (int i = 0; i < 3; i++) srcA.push_back(64'h4000 + 64'(i));
    feed(100, 0, 20);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1 || k == 4 || k == 7) begin
        r = 64'h4000 + 64'(cnt);
        applyStimulus(1'b0, '0, 1'b1, r, 1'b0, 1'b0, 1'b0);
        if (lastB) cnt++;
      end else idleCycle();
      if (k == 5) checkOutput("t5_still_drain", 64'(state), 64'd2);
    end
    checkOutput("t5_state", 64'(state), 64'd3);
    checkOutput("t5_match", 64'(match_count), 64'd3);

    // Asynchronous reset mid-run discards in-flight records.
    restart();
    for (int i = 0; i < 4; i++) srcA.push_back(64'h5000 + 64'(i));
    for (int i = 0; i < 2; i++) srcB.push_back(64'h5000 + 64'(i));
    feed(100, 100, 20);
    doReset();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h6000, 1'b1, 64'h6000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    waitDone(20);
    checkOutput("t6_match", 64'(match_count), 64'd1);
    checkOutput("t6_state", 64'(state), 64'd3);

    // Randomized runs, some with an injected mismatch.
    for (int run = 0; run < 8; run++) begin
      int n;
      int bad_idx;
      restart();
      n = $urandom_range(30, 5);
      bad_idx = (run % 2 == 1) ? $urandom_range(n - 1, 0) : -1;
      for (int i = 0; i < n; i++) begin
        r = {$urandom, $urandom};
        srcA.push_back(r);
        srcB.push_back((i == bad_idx) ? (r ^ 64'h1) : r);
      end
      feed($urandom_range(100, 50), $urandom_range(100, 50), 400);
      srcA.delete();
      srcB.delete();
      if (m_state == 1) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      waitDone(100);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
